display_formatter: RTL and testbench



---
 rtl/display_formatter_pkg.sv | 31 +++
 rtl/display_formatter_bcd_add3.sv | 18 +
 rtl/display_formatter.sv | 133 +++++++++++++
 tb/tb_display_formatter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_formatter_pkg.sv
// Shared definitions for the display formatter: FSM encoding, digit constants
// and the significant-digit helper used when publishing a result.
package display_formatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int         NUM_DIGITS      = 4;
  localparam int         BCD_W           = 4 * NUM_DIGITS;
  localparam int         CNT_W           = 5;
  localparam int         DEFAULT_MAX_DEC = 9999;
  localparam logic [3:0] DIGIT_ERR       = 4'hE;
  localparam logic [3:0] DIGIT_BLANK_N   = 4'd0;

  // Number of digits from the most significant non-zero one down to the ones
  // digit; an all-zero word still shows a single 0.
  function automatic logic [3:0] sig_digits(input logic [BCD_W-1:0] digits);
    logic [3:0] count;
    count = 4'd1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (digits[i*4 +: 4] != 4'd0) begin
        count = 4'(i + 1);
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/display_formatter_bcd_add3.sv
// Per-digit add-3 adjust for the double-dabble step: every BCD digit of 5 or
// more gets 3 added so the following left shift carries into the next digit.
module display_formatter_bcd_add3
  import display_formatter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [BCD_W-1:0] bcd_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign bcd_o[gi*4 +: 4] = (bcd_i[gi*4 +: 4] >= 4'd5) ? (bcd_i[gi*4 +: 4] + 4'd3)
                                                            : bcd_i[gi*4 +: 4];
    end
  endgenerate

endmodule

// File: rtl/display_formatter.sv
// Converts a binary calculator result into a digit count and four display
// nibbles (decimal via iterative double-dabble, or raw hex), double-buffered.
module display_formatter
  import display_formatter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_DEC = DEFAULT_MAX_DEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             hexMode,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       n,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4
);

  localparam logic [WIDTH-1:0] MAX_DEC_V = WIDTH'(MAX_DEC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [3:0]         n_q, n_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic               overflow;

  assign overflow = (value > MAX_DEC_V);

  display_formatter_bcd_add3 u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      n_q      <= DIGIT_BLANK_N;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      n_q      <= n_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = (hexMode || overflow) ? ST_FINISH : ST_CONV;
        ST_CONV:   if (cnt_q == CNT_LAST) state_d = ST_FINISH;
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // bcd_q doubles as the result holding register for hex and overflow loads,
  // so FINISH always publishes from the same place.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    n_d      = n_q;
    done_d   = 1'b0;
    if (clear) begin
      bin_d    = '0;
      bcd_d    = '0;
      cnt_d    = '0;
      digits_d = '0;
      n_d      = DIGIT_BLANK_N;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (hexMode) begin
              bcd_d = BCD_W'(value);
            end else if (overflow) begin
              bcd_d = {NUM_DIGITS{DIGIT_ERR}};
            end else begin
              bin_d = value;
              bcd_d = '0;
              cnt_d = '0;
            end
          end
        end
        ST_CONV: begin
          {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        ST_FINISH: begin
          digits_d = bcd_q;
          n_d      = sig_digits(bcd_q);
          done_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = done_q;
    n    = n_q;
    num1 = digits_q[15:12];
    num2 = digits_q[11:8];
    num3 = digits_q[7:4];
    num4 = digits_q[3:0];
  end

endmodule

// File: tb/tb_display_formatter.sv
// Directed bench for display_formatter: a transaction-level model checked every
// cycle, plus literal expectations for latency and results of each case.
`timescale 1ns/1ps
module tb_display_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        hexMode = 1'b0;
  logic [15:0] value = 16'd0;
  logic        busy, done;
  logic [3:0]  n, num1, num2, num3, num4;

  int checks = 0;
  int errors = 0;

  // model state: outputs the display should show and cycles left until done
  int          m_remain = 0;
  int          m_n = 0;
  logic [15:0] m_digits = 16'd0;
  int          m_done = 0;
  int          p_n = 0;
  logic [15:0] p_digits = 16'd0;

  display_formatter #(.WIDTH(16), .MAX_DEC(9999)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .clear   (clear),
    .hexMode (hexMode),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .n       (n),
    .num1    (num1),
    .num2    (num2),
    .num3    (num3),
    .num4    (num4)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void predict(input logic h, input int v, output int pn,
                                  output logic [15:0] pd, output int lat);
    int d[4];
    if (h) begin
      for (int i = 0; i < 4; i++) d[i] = (v / (1 << (12 - 4 * i))) % 16;
    end else if (v > 9999) begin
      for (int i = 0; i < 4; i++) d[i] = 14;
    end else begin
      d[0] = (v / 1000) % 10;
      d[1] = (v / 100) % 10;
      d[2] = (v / 10) % 10;
      d[3] = v % 10;
    end
    if (d[0] != 0)      pn = 4;
    else if (d[1] != 0) pn = 3;
    else if (d[2] != 0) pn = 2;
    else                pn = 1;
    pd  = {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
    lat = (h || v > 9999) ? 1 : 17;
  endfunction

  task automatic model_step();
    int lat;
    m_done = 0;
    if (!reset) begin
      m_remain = 0; m_n = 0; m_digits = 16'd0;
    end else if (clear) begin
      m_remain = 0; m_n = 0; m_digits = 16'd0;
    end else if (m_remain > 0) begin
      m_remain--;
      if (m_remain == 0) begin
        m_n = p_n; m_digits = p_digits; m_done = 1;
      end
    end else if (start) begin
      predict(hexMode, int'(value), p_n, p_digits, lat);
      m_remain = lat;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("model_busy", int'(busy), (m_remain > 0) ? 1 : 0);
      chk("model_done", int'(done), m_done);
      chk("model_n", int'(n), m_n);
      chk("model_digits", int'({num1, num2, num3, num4}), int'(m_digits));
    end
  end

  task automatic start_pulse(input logic h, input logic [15:0] v);
    @(negedge clk);
    start = 1'b1; hexMode = h; value = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #2;
      if (done) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #2;
      if (done) cnt++;
    end
  endtask

  task automatic run_conv(input logic h, input logic [15:0] v, input int en,
                          input logic [15:0] ed, input int elat);
    int cyc;
    int busy_cnt;
    start_pulse(h, v);
    busy_cnt = busy ? 1 : 0;
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #2;
      if (done) begin
        cyc = c;
        break;
      end
      if (busy) busy_cnt++;
    end
    chk("latency", cyc, elat);
    chk("busy_cycles", busy_cnt, elat);
    chk("busy_low_at_done", int'(busy), 0);
    chk("result_n", int'(n), en);
    chk("result_digits", int'({num1, num2, num3, num4}), int'(ed));
    $display("conv hex=%0d value=0x%04h -> n=%0d digits=%h%h%h%h latency=%0d",
             h, v, n, num1, num2, num3, num4, cyc);
  endtask

  initial begin
    int cyc;
    int cnt;

    #5;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_n", int'(n), 0);
    chk("reset_digits", int'({num1, num2, num3, num4}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_dones(5, cnt);
    chk("idle_no_done", cnt, 0);
    $display("reset and idle complete");

    run_conv(1'b0, 16'd1234,  4, 16'h1234, 17);
    run_conv(1'b0, 16'd7,     1, 16'h0007, 17);
    run_conv(1'b0, 16'd0,     1, 16'h0000, 17);
    run_conv(1'b0, 16'd9999,  4, 16'h9999, 17);
    run_conv(1'b0, 16'd100,   3, 16'h0100, 17);
    run_conv(1'b0, 16'd10000, 4, 16'hEEEE, 1);
    run_conv(1'b1, 16'h00AF,  2, 16'h00AF, 1);
    run_conv(1'b1, 16'hFFFF,  4, 16'hFFFF, 1);

    // start during a conversion is dropped; display holds 00AF-style old value until done
    run_conv(1'b1, 16'h00AF,  2, 16'h00AF, 1);
    start_pulse(1'b0, 16'd1234);
    repeat (4) @(negedge clk);
    start_pulse(1'b0, 16'd5678);
    chk("hold_n_midconv", int'(n), 2);
    chk("hold_digits_midconv", int'({num1, num2, num3, num4}), 16'h00AF);
    wait_done(cyc);
    chk("midstart_done_seen", (cyc > 0) ? 1 : 0, 1);
    chk("midstart_digits", int'({num1, num2, num3, num4}), 16'h1234);
    count_dones(20, cnt);
    chk("midstart_single_done", cnt, 0);
    $display("ignored start during conversion: digits=%h%h%h%h", num1, num2, num3, num4);

    // clear at cycle 8 of conversion
    start_pulse(1'b0, 16'd4321);
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_busy", int'(busy), 0);
    chk("clear_n", int'(n), 0);
    chk("clear_digits", int'({num1, num2, num3, num4}), 0);
    count_dones(25, cnt);
    chk("clear_no_done", cnt, 0);
    $display("clear during conversion: n=%0d busy=%0d", n, busy);

    run_conv(1'b0, 16'd9999, 4, 16'h9999, 17);

    // clear and start together
    @(negedge clk);
    clear = 1'b1; start = 1'b1; hexMode = 1'b0; value = 16'd55;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("clrstart_busy", int'(busy), 0);
    chk("clrstart_n", int'(n), 0);
    count_dones(25, cnt);
    chk("clrstart_no_done", cnt, 0);
    $display("clear with start: n=%0d busy=%0d", n, busy);

    run_conv(1'b0, 16'd42, 2, 16'h0042, 17);

    // asynchronous reset at cycle 5 of conversion
    start_pulse(1'b0, 16'd4321);
    repeat (4) @(negedge clk);
    #5 reset = 1'b0;
    #1;
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_n", int'(n), 0);
    chk("async_reset_digits", int'({num1, num2, num3, num4}), 0);
    @(negedge clk);
    reset = 1'b1;
    count_dones(25, cnt);
    chk("async_reset_no_done", cnt, 0);
    $display("reset during conversion: n=%0d busy=%0d", n, busy);

    run_conv(1'b1, 16'h1000, 4, 16'h1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
